// File: rtl/obj_line_seq.sv
// Object line-buffer write sequencer: serialises fetched object words pixel by pixel
// on pixel-clock ticks and writes opaque pixels into rotating line buffers.
module obj_line_seq #(
  parameter int PIX_PER_WORD = 4,
  parameter int PIX_BITS     = 4,
  parameter int XW           = 9,
  parameter int NBUF         = 2,
  localparam int BW          = ($clog2(NBUF) > 1) ? $clog2(NBUF) : 1
) (
  input  logic                             clk,
  input  logic                             Reset_n,
  input  logic                             Cen,
  input  logic                             hblank,
  input  logic                             word_valid,
  input  logic [PIX_PER_WORD*PIX_BITS-1:0] word_data,
  input  logic [XW-1:0]                    word_x,
  input  logic                             word_flip,
  output logic                             word_ready,
  output logic                             pload_n,
  output logic                             busy,
  output logic                             wr_en,
  output logic [XW-1:0]                    wr_addr,
  output logic [PIX_BITS-1:0]              wr_pix,
  output logic [BW-1:0]                    wr_buf,
  output logic [BW-1:0]                    rd_buf
);

  localparam int CW = $clog2(PIX_PER_WORD);
  localparam int WW = PIX_PER_WORD * PIX_BITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PIX_PER_WORD - 1);
  localparam logic [BW-1:0] BUF_LAST = BW'(NBUF - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic                last_cen_q;
  logic                hb_q, hb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]       word_q, word_d;
  logic [XW-1:0]       x_q, x_d;
  logic                flip_q, flip_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic [XW-1:0]       wr_addr_q, wr_addr_d;
  logic [PIX_BITS-1:0] wr_pix_q, wr_pix_d;
  logic [BW-1:0]       wr_buf_q, wr_buf_d;
  logic [BW-1:0]       rd_buf_q, rd_buf_d;

  logic                tick;
  logic                line_edge;
  logic                load;
  logic [CW-1:0]       pix_idx;
  logic [PIX_BITS-1:0] cur_pix;
  logic [PIX_BITS-1:0] pix_arr [PIX_PER_WORD];

  // Unpack the latched word into per-pixel lanes for the serialiser mux.
  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix
      assign pix_arr[gi] = word_q[gi*PIX_BITS +: PIX_BITS];
    end
  endgenerate

  assign tick      = Cen & ~last_cen_q;
  assign line_edge = tick & hblank & ~hb_q;

  always_comb begin
    pix_idx = flip_q ? (CNT_LAST - cnt_q) : cnt_q;
    cur_pix = pix_arr[pix_idx];
  end

  always_comb begin
    state_d   = state_q;
    hb_d      = hb_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    x_d       = x_q;
    flip_d    = flip_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_pix_d  = wr_pix_q;
    wr_buf_d  = wr_buf_q;
    rd_buf_d  = rd_buf_q;
    load      = 1'b0;

    if (tick) begin
      hb_d = hblank;
      if (line_edge) begin
        // Line start aborts any word in flight and flips display/write buffers.
        wr_buf_d = (wr_buf_q == BUF_LAST) ? '0 : wr_buf_q + BW'(1);
        rd_buf_d = wr_buf_q;
        state_d  = IDLE;
        cnt_d    = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (word_valid) begin
              load = 1'b1;
            end
          end
          SHIFT: begin
            wr_en_d   = (cur_pix != '0);
            wr_addr_d = x_q + XW'(cnt_q);
            wr_pix_d  = cur_pix;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              if (word_valid) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (load) begin
        word_d  = word_data;
        x_d     = word_x;
        flip_d  = word_flip;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      last_cen_q <= 1'b1;
      hb_q       <= 1'b0;
      cnt_q      <= '0;
      word_q     <= '0;
      x_q        <= '0;
      flip_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_pix_q   <= '0;
      wr_buf_q   <= '0;
      rd_buf_q   <= BUF_LAST;
    end else begin
      state_q    <= state_d;
      last_cen_q <= Cen;
      hb_q       <= hb_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      x_q        <= x_d;
      flip_q     <= flip_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_pix_q   <= wr_pix_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  assign word_ready = load;
  assign pload_n    = ~load;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_pix     = wr_pix_q;
  assign wr_buf     = wr_buf_q;
  assign rd_buf     = rd_buf_q;

endmodule

// File: tb/tb_obj_line_seq.sv
// Scoreboard bench for obj_line_seq: expected line-buffer writes are queued as words
// are loaded and matched against every wr_en pulse; a second instance runs with NBUF=3.
module tb_obj_line_seq;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        Cen;
  logic        hblank;
  logic        word_valid;
  logic [15:0] word_data;
  logic [8:0]  word_x;
  logic        word_flip;

  logic        word_ready, pload_n, busy, wr_en;
  logic [8:0]  wr_addr;
  logic [3:0]  wr_pix;
  logic [0:0]  wr_buf, rd_buf;

  logic        word_ready_3, pload_n_3, busy_3, wr_en_3;
  logic [8:0]  wr_addr_3;
  logic [3:0]  wr_pix_3;
  logic [1:0]  wr_buf_3, rd_buf_3;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          exp_wb = 0, exp_rb = 1, exp_wb3 = 0, exp_rb3 = 2;
  logic        wr_en_prev = 1'b0;

  always #5 clk = ~clk;

  obj_line_seq #(.PIX_PER_WORD(4), .PIX_BITS(4), .XW(9), .NBUF(2)) u_dut (
    .clk(clk), .Reset_n(Reset_n), .Cen(Cen), .hblank(hblank),
    .word_valid(word_valid), .word_data(word_data), .word_x(word_x), .word_flip(word_flip),
    .word_ready(word_ready), .pload_n(pload_n), .busy(busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_pix(wr_pix), .wr_buf(wr_buf), .rd_buf(rd_buf)
  );

  obj_line_seq #(.PIX_PER_WORD(4), .PIX_BITS(4), .XW(9), .NBUF(3)) u_dut3 (
    .clk(clk), .Reset_n(Reset_n), .Cen(Cen), .hblank(hblank),
    .word_valid(word_valid), .word_data(word_data), .word_x(word_x), .word_flip(word_flip),
    .word_ready(word_ready_3), .pload_n(pload_n_3), .busy(busy_3), .wr_en(wr_en_3),
    .wr_addr(wr_addr_3), .wr_pix(wr_pix_3), .wr_buf(wr_buf_3), .rd_buf(rd_buf_3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pk(input int b, input int a, input int p);
    return 32'((b << 16) | (a << 4) | p);
  endfunction

  // Every write strobe must be one clk wide and match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      check_eq("wr_en_width", {31'd0, wr_en_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", pk(int'(wr_buf), int'(wr_addr), int'(wr_pix)), 32'hFFFF_FFFF);
      end else begin
        check_eq("wr", pk(int'(wr_buf), int'(wr_addr), int'(wr_pix)), exp_q.pop_front());
      end
    end
    wr_en_prev = wr_en;
  end

  task automatic tick(input logic exp_rdy, input string tag);
    logic nr;
    nr = ~exp_rdy;
    @(negedge clk);
    Cen = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, {31'd0, word_ready}, {31'd0, exp_rdy});
    check_eq({tag, "_pload_n"}, {31'd0, pload_n}, {31'd0, nr});
    @(negedge clk);
    Cen = 1'b0;
  endtask

  task automatic set_word(input logic [15:0] d, input int x, input logic f);
    word_valid = 1'b1;
    word_data  = d;
    word_x     = 9'(x);
    word_flip  = f;
  endtask

  task automatic expect_word(input logic [15:0] d, input int x, input logic f, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      int p;
      idx = f ? 3 - i : i;
      p = int'((d >> (idx * 4)) & 16'hF);
      if (p != 0) exp_q.push_back(pk(exp_wb, (x + i) % 512, p));
    end
  endtask

  task automatic check_bufs(input string tag);
    check_eq({tag, "_wr_buf"}, {31'd0, wr_buf}, 32'(exp_wb));
    check_eq({tag, "_rd_buf"}, {31'd0, rd_buf}, 32'(exp_rb));
    check_eq({tag, "_wr_buf3"}, {30'd0, wr_buf_3}, 32'(exp_wb3));
    check_eq({tag, "_rd_buf3"}, {30'd0, rd_buf_3}, 32'(exp_rb3));
  endtask

  task automatic model_edge();
    exp_rb  = exp_wb;
    exp_wb  = (exp_wb + 1) % 2;
    exp_rb3 = exp_wb3;
    exp_wb3 = (exp_wb3 + 1) % 3;
  endtask

  // Emit n pixel ticks after a load, checking busy drops only after the last one.
  task automatic drain_word(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, tag);
      check_eq({tag, "_busy"}, {31'd0, busy}, (i < 3) ? 32'd1 : 32'd0);
    end
    tick(1'b0, {tag, "_idle"});
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    Cen = 1'b1;
    hblank = 1'b0;
    set_word(16'h4321, 10, 1'b0);
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;

    // Cen high across reset release must not produce a tick.
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_rdy", {31'd0, word_ready}, 32'd0);
    end
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_eq("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
    check_eq("rst_wr_pix", {28'd0, wr_pix}, 32'd0);
    check_eq("rst_pload_n", {31'd0, pload_n}, 32'd1);
    check_bufs("rst");
    Cen = 1'b0;

    // Plain word
    tick(1'b1, "t1_load");
    word_valid = 1'b0;
    check_eq("t1_busy_ld", {31'd0, busy}, 32'd1);
    expect_word(16'h4321, 10, 1'b0, 4);
    drain_word("t1");

    // Flipped word with a transparent pixel
    set_word(16'h4021, 10, 1'b1);
    tick(1'b1, "t2_load");
    word_valid = 1'b0;
    expect_word(16'h4021, 10, 1'b1, 4);
    drain_word("t2");

    // Address wrap and back-to-back reload
    set_word(16'h8765, 510, 1'b0);
    tick(1'b1, "t3_load");
    expect_word(16'h8765, 510, 1'b0, 4);
    set_word(16'hCBA9, 20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, "t3_px");
      check_eq("t3_busy", {31'd0, busy}, 32'd1);
    end
    tick(1'b1, "t3_reload");
    word_valid = 1'b0;
    check_eq("t3_busy_reload", {31'd0, busy}, 32'd1);
    expect_word(16'hCBA9, 20, 1'b1, 4);
    drain_word("t3b");

    // Line edge aborts a word after two pixels; pending word loads next tick
    set_word(16'h5555, 100, 1'b0);
    tick(1'b1, "t4_load");
    word_valid = 1'b0;
    expect_word(16'h5555, 100, 1'b0, 2);
    tick(1'b0, "t4_px");
    tick(1'b0, "t4_px");
    set_word(16'h2222, 200, 1'b0);
    hblank = 1'b1;
    tick(1'b0, "t4_edge");
    model_edge();
    check_bufs("t4_edge");
    check_eq("t4_busy_edge", {31'd0, busy}, 32'd0);
    tick(1'b1, "t4_reload");
    word_valid = 1'b0;
    hblank = 1'b0;
    expect_word(16'h2222, 200, 1'b0, 4);
    drain_word("t4b");

    // Two more line edges for the NBUF=3 rotation
    for (int k = 0; k < 2; k++) begin
      hblank = 1'b1;
      tick(1'b0, "t5_edge");
      model_edge();
      check_bufs("t5");
      hblank = 1'b0;
      tick(1'b0, "t5_low");
    end

    // Reset mid-word discards the rest of the word
    set_word(16'h3333, 40, 1'b0);
    tick(1'b1, "t6_load");
    word_valid = 1'b0;
    expect_word(16'h3333, 40, 1'b0, 1);
    tick(1'b0, "t6_px");
    @(negedge clk);
    Reset_n = 1'b0;
    Cen = 1'b1;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_wb = 0; exp_rb = 1; exp_wb3 = 0; exp_rb3 = 2;
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_bufs("t6");
    Cen = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, "t6_after");
    check_eq("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
